// File: rtl/gaussian_noise_gen_v3.sv
// gaussian_noise_gen_v3: approximate-Gaussian noise source.
// Each of NSAMP lanes sums NTERMS maximal-length LFSRs through a registered
// adder tree, removes the DC mean, applies a power-of-two gain and emits a
// signed OUT_W sample. A small LOAD/FILL/RUN controller handles reseeding and
// pipeline fill so that valid_o only marks samples from the current seed.
// Optional build macro GAUSS_SAT_EN: clamp the scaled sample to the OUT_W
// signed range instead of keeping its low OUT_W bits (two's-complement wrap).
module gaussian_noise_gen_v3 #(
  parameter int                NSAMP     = 8,
  parameter int                NTERMS    = 16,
  parameter int                LFSR_W    = 8,
  parameter int                OUT_W     = 16,
  parameter logic [LFSR_W-1:0] SEED_BASE = LFSR_W'(1)
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   seed_load_i,
  input  logic [LFSR_W-1:0]      seed_i,
  input  logic [3:0]             gain_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [NSAMP*OUT_W-1:0] data_o
);

  // Feedback tap masks (bit k set = tap at bit k) for maximal-length sequences.
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam int LEVELS = $clog2(NTERMS);
  localparam int NPAD   = 1 << LEVELS;
  localparam int SUM_W  = LFSR_W + LEVELS;
  localparam int LAT    = LEVELS + 1;
  localparam int CNT_W  = $clog2(LAT + 1);
  localparam int EXT_W  = SUM_W + 16;
  // Keep at least one guard bit above OUT_W so wrap/clamp see the true sign.
  localparam int CALC_W = (EXT_W > OUT_W) ? EXT_W : OUT_W + 1;

  localparam logic [LFSR_W-1:0]        TAPS    = LFSR_W'(tap_mask(LFSR_W));
  // Mean of a nonzero LFSR value is exactly 2^(LFSR_W-1); NTERMS of them summed.
  localparam logic signed [SUM_W:0]    MEAN_S  = $signed((SUM_W+1)'(NTERMS << (LFSR_W-1)));
  localparam logic signed [CALC_W-1:0] SAT_MAX = {{(CALC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] SAT_MIN = {{(CALC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Seed of LFSR number idx; the all-zero lock-up state is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] base, input int idx);
    logic [LFSR_W-1:0] v;
    v = base + LFSR_W'(idx);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  // Mean removal, gain shift and final width reduction for one lane.
  function automatic logic [OUT_W-1:0] shape(input logic [SUM_W-1:0] sum, input logic [3:0] gain);
    logic signed [SUM_W:0]    centred;
    logic signed [CALC_W-1:0] ext;
    logic signed [CALC_W-1:0] scaled;
    centred = $signed({1'b0, sum}) - MEAN_S;
    ext     = {{(CALC_W-SUM_W-1){centred[SUM_W]}}, centred};
    scaled  = ext <<< gain;
`ifdef GAUSS_SAT_EN
    if (scaled > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (scaled < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end else begin
      return scaled[OUT_W-1:0];
    end
`else
    return scaled[OUT_W-1:0];
`endif
  endfunction

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  fill_cnt_r;
  logic [LFSR_W-1:0] base_r;
  logic              valid_r;
  logic              busy_r;
  logic [LFSR_W-1:0] lfsr_r [NSAMP][NTERMS];
  logic [SUM_W-1:0]  leaf_s [NSAMP][NPAD];
  logic [SUM_W-1:0]  root_s [NSAMP];
  logic [OUT_W-1:0]  data_r [NSAMP];

  // Controller: reseed capture, one-cycle LOAD, LAT enabled FILL cycles, RUN.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_LOAD;
      fill_cnt_r <= '0;
      base_r     <= SEED_BASE;
      valid_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else if (seed_load_i) begin
      state_r    <= ST_LOAD;
      fill_cnt_r <= '0;
      base_r     <= seed_i;
      valid_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      case (state_r)
        ST_LOAD: begin
          state_r    <= ST_FILL;
          fill_cnt_r <= '0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b1;
        end
        ST_FILL: begin
          if (enable_i) begin
            if (fill_cnt_r == CNT_W'(LAT - 1)) begin
              state_r <= ST_RUN;
              valid_r <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              fill_cnt_r <= fill_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_LOAD;
          fill_cnt_r <= '0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  // LFSR bank: seeded in LOAD, stepped on every enabled cycle otherwise.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NSAMP; s++)
        for (int t = 0; t < NTERMS; t++)
          lfsr_r[s][t] <= seed_of(SEED_BASE, s * NTERMS + t);
    end else if (state_r == ST_LOAD) begin
      for (int s = 0; s < NSAMP; s++)
        for (int t = 0; t < NTERMS; t++)
          lfsr_r[s][t] <= seed_of(base_r, s * NTERMS + t);
    end else if (enable_i) begin
      for (int s = 0; s < NSAMP; s++)
        for (int t = 0; t < NTERMS; t++)
          lfsr_r[s][t] <= lfsr_step(lfsr_r[s][t]);
    end
  end

  // Tree leaves: LFSR values zero-extended, padded with zeros to a power of two.
  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      for (int p = 0; p < NPAD; p++)
        leaf_s[s][p] = '0;
      for (int t = 0; t < NTERMS; t++)
        leaf_s[s][t] = SUM_W'(lfsr_r[s][t]);
    end
  end

  if (LEVELS > 0) begin : g_tree
    // Heap-ordered nodes: node n sums children 2n and 2n+1; node 1 is the root.
    logic [SUM_W-1:0] node_r [NSAMP][1:NPAD-1];

    // Registered adder tree, one level per enabled cycle, cleared in LOAD.
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < NSAMP; s++)
          for (int n = 1; n < NPAD; n++)
            node_r[s][n] <= '0;
      end else if (state_r == ST_LOAD) begin
        for (int s = 0; s < NSAMP; s++)
          for (int n = 1; n < NPAD; n++)
            node_r[s][n] <= '0;
      end else if (enable_i) begin
        for (int s = 0; s < NSAMP; s++) begin
          for (int n = 1; n < NPAD / 2; n++)
            node_r[s][n] <= node_r[s][2*n] + node_r[s][2*n+1];
          for (int n = NPAD / 2; n < NPAD; n++)
            node_r[s][n] <= leaf_s[s][2*n-NPAD] + leaf_s[s][2*n+1-NPAD];
        end
      end
    end

    // Root of each lane's tree feeds the output stage.
    always_comb begin
      for (int s = 0; s < NSAMP; s++)
        root_s[s] = node_r[s][1];
    end
  end else begin : g_flat
    // Single-term lanes: the LFSR register itself is the sum.
    always_comb begin
      for (int s = 0; s < NSAMP; s++)
        root_s[s] = leaf_s[s][0];
    end
  end

  // Output stage: gain sampled here; holds while enable_i is low.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NSAMP; s++)
        data_r[s] <= '0;
    end else if (enable_i) begin
      for (int s = 0; s < NSAMP; s++)
        data_r[s] <= shape(root_s[s], gain_i);
    end
  end

  for (genvar g = 0; g < NSAMP; g++) begin : g_out
    assign data_o[g*OUT_W +: OUT_W] = data_r[g];
  end

  assign valid_o = valid_r;
  assign busy_o  = busy_r;

endmodule
